// File: rtl/vending_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vending_pkg
// Description : State encoding, coin values and the one-hot decode helper
//               shared by the vending controller files.
// Revision    : 1.0 - initial release
// ============================================================================
package vending_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    localparam int COIN_Q = 25;
    localparam int COIN_D = 100;

    // Index of the highest set bit; only meaningful when v is one-hot.
    function automatic int onehot_to_idx(input logic [63:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_unit.sv
`default_nettype none
// ============================================================================
// Module      : vend_change_unit
// Description : Paces change pulses GAP_CYC apart and picks dollar/quarter;
//               requests a credit decrement in the cycle each pulse is issued.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_change_unit
    import vending_pkg::*;
#(
    parameter int MONEY_W = 12,
    parameter int GAP_CYC = 25_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [MONEY_W-1:0] i_credit,
    output logic               o_take_d,
    output logic               o_take_q,
    output logic               o_change_d,
    output logic               o_change_q,
    output logic               o_done
);

    localparam int GW = $clog2(GAP_CYC);

    logic          r_active;
    logic [GW-1:0] r_gap;
    logic          r_change_d;
    logic          r_change_q;
    logic          w_run;
    logic          w_fire;

    assign w_run    = i_start | r_active;
    assign w_fire   = w_run && (r_gap == '0) && (i_credit != '0);
    assign o_take_d = w_fire && (i_credit >= MONEY_W'(COIN_D));
    assign o_take_q = w_fire && !o_take_d;
    assign o_done   = w_run && (i_credit == '0);

    assign o_change_d = r_change_d;
    assign o_change_q = r_change_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= 1'b0;
            r_gap      <= '0;
            r_change_d <= 1'b0;
            r_change_q <= 1'b0;
        end else begin
            r_change_d <= o_take_d;
            r_change_q <= o_take_q;
            if (o_done) begin
                r_active <= 1'b0;
                r_gap    <= '0;
            end else if (w_run) begin
                r_active <= 1'b1;
                r_gap    <= w_fire ? GW'(GAP_CYC - 1) : r_gap - GW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vending_core_n.sv
`default_nettype none
// ============================================================================
// Module      : vending_core_n
// Description : N-product vending controller with stock bank, credit cap,
//               cancel, inactivity refund and paced coin-by-coin change.
// Revision    : 1.0 - initial release
// ============================================================================
module vending_core_n
    import vending_pkg::*;
#(
    parameter int                        N_PROD      = 8,
    parameter int                        MONEY_W     = 12,
    parameter int                        STOCK_W     = 4,
    parameter int                        INIT_STOCK  = 5,
    parameter logic [N_PROD*MONEY_W-1:0] PRICES      = {N_PROD{MONEY_W'(125)}},
    parameter int                        MAX_CREDIT  = 995,
    parameter int                        TIMEOUT_CYC = 50_000_000,
    parameter int                        GAP_CYC     = 25_000_000
) (
    input  logic               clk,
    input  logic               btnR,
    input  logic               coin_q,
    input  logic               coin_d,
    input  logic               buy,
    input  logic               cancel,
    input  logic               restock,
    input  logic [N_PROD-1:0]  sel,
    output logic [MONEY_W-1:0] credit,
    output logic [N_PROD-1:0]  vend,
    output logic [N_PROD-1:0]  sold_out,
    output logic               coin_reject,
    output logic               sel_err,
    output logic               change_d,
    output logic               change_q,
    output logic               refund_led,
    output logic               busy
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int XW = MONEY_W + 1;
    localparam int IW = (N_PROD > 1) ? $clog2(N_PROD) : 1;

    state_t             r_state;
    logic [MONEY_W-1:0] r_credit;
    logic [STOCK_W-1:0] r_stock [N_PROD];
    logic [N_PROD-1:0]  r_vend;
    logic               r_coin_reject;
    logic               r_sel_err;
    logic               r_chg_start;
    logic [TW-1:0]      r_timer;

    logic               w_coin_any;
    logic [XW-1:0]      w_coin_sum;
    logic               w_coin_ok;
    logic               w_coin_rej;
    logic [IW-1:0]      w_idx;
    logic [MONEY_W-1:0] w_price;
    logic               w_buy_ok;
    logic               w_buy_err;
    logic               w_take_d;
    logic               w_take_q;
    logic               w_chg_done;

    // Dollar wins a simultaneous coin pair; the quarter is always bounced.
    assign w_coin_any = coin_q | coin_d;
    assign w_coin_sum = {1'b0, r_credit} + (coin_d ? XW'(COIN_D) : XW'(COIN_Q));
    assign w_coin_ok  = w_coin_any && !buy && !cancel
                        && ((r_state == ST_IDLE) || (r_state == ST_CREDIT))
                        && (w_coin_sum <= XW'(MAX_CREDIT));
    assign w_coin_rej = (w_coin_any && !w_coin_ok) || (coin_q && coin_d);

    assign w_idx     = IW'(onehot_to_idx(64'(sel)));
    assign w_price   = PRICES[int'(w_idx) * MONEY_W +: MONEY_W];
    assign w_buy_ok  = (r_state == ST_CREDIT) && buy && !cancel && $onehot(sel)
                       && (r_stock[w_idx] != '0)
                       && ({1'b0, r_credit} >= {1'b0, w_price});
    assign w_buy_err = buy && !cancel && !w_buy_ok
                       && ((r_state == ST_IDLE) || (r_state == ST_CREDIT));

    vend_change_unit #(
        .MONEY_W (MONEY_W),
        .GAP_CYC (GAP_CYC)
    ) u_change (
        .clk        (clk),
        .rst_n      (btnR),
        .i_start    (r_chg_start),
        .i_credit   (r_credit),
        .o_take_d   (w_take_d),
        .o_take_q   (w_take_q),
        .o_change_d (change_d),
        .o_change_q (change_q),
        .o_done     (w_chg_done)
    );

    always_ff @(posedge clk or negedge btnR) begin
        if (!btnR) begin
            r_state       <= ST_IDLE;
            r_credit      <= '0;
            r_vend        <= '0;
            r_coin_reject <= 1'b0;
            r_sel_err     <= 1'b0;
            r_chg_start   <= 1'b0;
            r_timer       <= '0;
            for (int i = 0; i < N_PROD; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            r_coin_reject <= w_coin_rej;
            r_sel_err     <= w_buy_err;
            r_chg_start   <= 1'b0;
            if (w_coin_any || buy || cancel) r_vend <= '0;

            case (r_state)
                ST_IDLE: begin
                    r_timer <= '0;
                    if (restock) begin
                        for (int i = 0; i < N_PROD; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
                    end
                    if (w_coin_ok) begin
                        r_credit <= w_coin_sum[MONEY_W-1:0];
                        r_state  <= ST_CREDIT;
                    end
                end
                ST_CREDIT: begin
                    if (cancel) begin
                        r_timer     <= '0;
                        r_chg_start <= 1'b1;
                        r_state     <= ST_CHANGE;
                    end else if (buy) begin
                        r_timer <= '0;
                        if (w_buy_ok) begin
                            r_credit       <= r_credit - w_price;
                            r_stock[w_idx] <= r_stock[w_idx] - STOCK_W'(1);
                            r_vend         <= sel;
                            r_state        <= ST_VEND;
                        end
                    end else if (w_coin_ok) begin
                        r_credit <= w_coin_sum[MONEY_W-1:0];
                        r_timer  <= '0;
                    end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
                        r_timer     <= '0;
                        r_chg_start <= 1'b1;
                        r_state     <= ST_CHANGE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                ST_VEND: begin
                    if (r_credit != '0) begin
                        r_chg_start <= 1'b1;
                        r_state     <= ST_CHANGE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CHANGE: begin
                    if (w_take_d)      r_credit <= r_credit - MONEY_W'(COIN_D);
                    else if (w_take_q) r_credit <= r_credit - MONEY_W'(COIN_Q);
                    if (w_chg_done)    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < N_PROD; g++) begin : g_sold_out
        assign sold_out[g] = (r_stock[g] == '0);
    end

    assign credit      = r_credit;
    assign vend        = r_vend;
    assign coin_reject = r_coin_reject;
    assign sel_err     = r_sel_err;
    assign refund_led  = (r_state == ST_CHANGE);
    assign busy        = (r_state == ST_VEND) || (r_state == ST_CHANGE);

endmodule
`default_nettype wire

// File: tb/tb_vending_core_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_vending_core_n
// Description : Scoreboard bench for vending_core_n: directed scenarios plus
//               randomized traffic against a credit/stock reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vending_core_n;

    localparam int K_D = 1;
    localparam int K_Q = 2;
    localparam logic [47:0] PR = {12'd100, 12'd150, 12'd75, 12'd125};

    logic        clk = 1'b0;
    logic        btnR = 1'b0;
    logic        coin_q = 1'b0, coin_d = 1'b0, buy = 1'b0, cancel = 1'b0, restock = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [11:0] credit;
    logic [3:0]  vend, sold_out;
    logic        coin_reject, sel_err, change_d, change_q, refund_led, busy;

    vending_core_n #(
        .N_PROD(4), .MONEY_W(12), .STOCK_W(4), .INIT_STOCK(2), .PRICES(PR),
        .MAX_CREDIT(995), .TIMEOUT_CYC(200), .GAP_CYC(4)
    ) dut (
        .clk(clk), .btnR(btnR), .coin_q(coin_q), .coin_d(coin_d), .buy(buy),
        .cancel(cancel), .restock(restock), .sel(sel), .credit(credit), .vend(vend),
        .sold_out(sold_out), .coin_reject(coin_reject), .sel_err(sel_err),
        .change_d(change_d), .change_q(change_q), .refund_led(refund_led), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    int q_rej[$];
    int q_err[$];
    int q_vend[$];
    int q_chg[$];
    int q_credit[$];

    // Reference model: what a customer would see, in cents and item counts.
    int m_price[4] = '{125, 75, 150, 100};
    int m_stock[4] = '{2, 2, 2, 2};
    int m_credit   = 0;
    bit m_in_credit = 1'b0;
    int clear_cyc  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic int pending();
        return q_rej.size() + q_err.size() + q_vend.size() + q_chg.size() + q_credit.size();
    endfunction

    function automatic int exp_sold_out();
        int r;
        r = 0;
        for (int i = 0; i < 4; i++) if (m_stock[i] == 0) r |= (1 << i);
        return r;
    endfunction

    function automatic void push_refund();
        while (m_credit > 0) begin
            if (m_credit >= 100) begin q_chg.push_back(K_D); m_credit -= 100; end
            else begin q_chg.push_back(K_Q); m_credit -= 25; end
            q_credit.push_back(m_credit);
        end
        m_in_credit = 1'b0;
    endfunction

    function automatic void model_step(input bit cq, input bit cd, input bit b,
                                       input bit cn, input bit rs, input logic [3:0] s);
        bit pre = m_in_credit;
        bit rej = 1'b0;
        bit err = 1'b0;
        bit refund = 1'b0;
        int val, idx;
        if (cq || cd) begin
            val = cd ? 100 : 25;
            if (cn || b || (m_credit + val > 995)) rej = 1'b1;
            else begin
                m_credit += val;
                m_in_credit = 1'b1;
                q_credit.push_back(m_credit);
                clear_cyc = cyc;
            end
            if (cq && cd) rej = 1'b1;
        end
        if (cn) begin
            if (pre) refund = 1'b1;
        end else if (b) begin
            clear_cyc = cyc;
            if (!pre || $countones(s) != 1) err = 1'b1;
            else begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (s[i]) idx = i;
                if (m_stock[idx] == 0 || m_credit < m_price[idx]) err = 1'b1;
                else begin
                    m_credit -= m_price[idx];
                    m_stock[idx]--;
                    q_vend.push_back(int'(s));
                    q_credit.push_back(m_credit);
                    if (m_credit > 0) refund = 1'b1;
                    else m_in_credit = 1'b0;
                end
            end
        end
        if (rs && !pre) for (int i = 0; i < 4; i++) m_stock[i] = 2;
        if (rej) q_rej.push_back(1);
        if (err) q_err.push_back(1);
        if (refund) push_refund();
    endfunction

    // Monitor: every observed output event consumes one expectation.
    logic [11:0] prev_credit = 12'd0;
    logic [3:0]  prev_vend   = 4'd0;
    always @(negedge clk) begin
        int e;
        if (coin_reject) begin
            chk("coin_reject_expected", (q_rej.size() > 0) ? 1 : 0, 1);
            if (q_rej.size() > 0) void'(q_rej.pop_front());
        end
        if (sel_err) begin
            chk("sel_err_expected", (q_err.size() > 0) ? 1 : 0, 1);
            if (q_err.size() > 0) void'(q_err.pop_front());
        end
        if (vend != prev_vend && vend != 4'd0) begin
            e = (q_vend.size() > 0) ? q_vend.pop_front() : -1;
            chk("vend", int'(vend), e);
        end
        if (change_d) begin
            e = (q_chg.size() > 0) ? q_chg.pop_front() : -1;
            chk("change_d_kind", K_D, e);
        end
        if (change_q) begin
            e = (q_chg.size() > 0) ? q_chg.pop_front() : -1;
            chk("change_q_kind", K_Q, e);
        end
        if (credit != prev_credit) begin
            e = (q_credit.size() > 0) ? q_credit.pop_front() : -1;
            chk("credit", int'(credit), e);
        end
        prev_credit = credit;
        prev_vend   = vend;
    end

    task automatic apply(input bit cq, input bit cd, input bit b, input bit cn,
                         input bit rs, input logic [3:0] s);
        @(posedge clk); #1;
        coin_q = cq; coin_d = cd; buy = b; cancel = cn; restock = rs; sel = s;
        model_step(cq, cd, b, cn, rs, s);
        @(posedge clk); #1;
        coin_q = 0; coin_d = 0; buy = 0; cancel = 0; restock = 0;
    endtask

    task automatic settle(input int budget);
        int n;
        n = 0;
        @(posedge clk); #1;
        while ((pending() != 0 || busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) begin
            n_total++;
            $display("FAIL settle: %0d expectations outstanding, busy=%0b after %0d cycles",
                     pending(), busy, budget);
            q_rej.delete(); q_err.delete(); q_vend.delete(); q_chg.delete(); q_credit.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic step(input bit cq, input bit cd, input bit b, input bit cn,
                        input bit rs, input logic [3:0] s);
        apply(cq, cd, b, cn, rs, s);
        settle(200);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] s;
        repeat (3) @(posedge clk);
        #1 btnR = 1'b1;
        @(posedge clk); #1;
        chk("reset_credit", int'(credit), 0);
        chk("reset_vend", int'(vend), 0);
        chk("reset_sold_out", int'(sold_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_refund_led", int'(refund_led), 0);

        // Q,Q,D then buy product 0 (125c) -> 25c change
        step(1,0,0,0,0,4'b0000); step(1,0,0,0,0,4'b0000); step(0,1,0,0,0,4'b0000);
        step(0,0,1,0,0,4'b0001);
        chk("after_buy0_idle", int'(busy), 0);

        // D then buy 150c -> sel_err, cancel refunds the dollar
        step(0,1,0,0,0,4'b0000);
        step(0,0,1,0,0,4'b0100);
        chk("credit_kept_after_sel_err", int'(credit), m_credit);
        step(0,0,0,1,0,4'b0000);

        // Deplete product 1 (75c), third buy rejected, restock clears sold_out
        for (int k = 0; k < 2; k++) begin
            step(1,0,0,0,0,4'b0); step(1,0,0,0,0,4'b0); step(1,0,0,0,0,4'b0);
            step(0,0,1,0,0,4'b0010);
        end
        chk("sold_out_p1", int'(sold_out), exp_sold_out());
        step(1,0,0,0,0,4'b0); step(1,0,0,0,0,4'b0); step(1,0,0,0,0,4'b0);
        step(0,0,1,0,0,4'b0010);
        step(0,0,0,1,0,4'b0000);
        step(0,0,0,0,1,4'b0000);
        chk("sold_out_restocked", int'(sold_out), exp_sold_out());

        // Credit cap: ten dollars, then Q, then D
        for (int k = 0; k < 10; k++) step(0,1,0,0,0,4'b0);
        chk("cap_credit_900", int'(credit), 900);
        step(1,0,0,0,0,4'b0);
        step(0,1,0,0,0,4'b0);
        chk("cap_credit_925", int'(credit), 925);
        step(0,0,0,1,0,4'b0);

        // Inactivity timeout refunds a single quarter
        apply(1,0,0,0,0,4'b0);
        q_chg.push_back(K_Q); q_credit.push_back(0);
        m_credit = 0; m_in_credit = 1'b0;
        repeat (150) @(posedge clk);
        #1 chk("no_early_timeout", int'(credit), 25);
        settle(150);

        // Coin during CHANGE is rejected
        step(0,1,0,0,0,4'b0); step(0,1,0,0,0,4'b0); step(0,1,0,0,0,4'b0);
        apply(0,0,0,1,0,4'b0);
        @(posedge clk); #1 coin_q = 1'b1; q_rej.push_back(1);
        chk("refund_led_in_change", int'(refund_led), 1);
        @(posedge clk); #1 coin_q = 1'b0;
        settle(200);

        // Buy and coin_d in the same cycle: buy wins, coin bounced
        for (int k = 0; k < 5; k++) step(1,0,0,0,0,4'b0);
        step(0,1,1,0,0,4'b0001);

        // Reset in the middle of CHANGE discards outstanding credit
        step(0,1,0,0,0,4'b0); step(0,1,0,0,0,4'b0); step(0,1,0,0,0,4'b0);
        @(posedge clk); #1 cancel = 1'b1;
        q_chg.push_back(K_D); q_credit.push_back(200);
        @(posedge clk); #1 cancel = 1'b0;
        n = 0;
        while (q_chg.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
        chk("first_change_seen", (n < 20) ? 1 : 0, 1);
        q_credit.push_back(0);
        btnR = 1'b0;
        m_credit = 0; m_in_credit = 1'b0;
        for (int i = 0; i < 4; i++) m_stock[i] = 2;
        repeat (3) @(posedge clk);
        #1 btnR = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_reset_credit", int'(credit), 0);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_sold_out", int'(sold_out), 0);

        // Randomized traffic
        for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 4) == 0) s = 4'($urandom_range(0, 15));
            else s = 4'(1 << $urandom_range(0, 3));
            if (m_in_credit && (cyc - clear_cyc) > 120) begin
                step(0,0,0,1,0,4'b0);
            end else begin
                case ($urandom_range(0, 19))
                    0,1,2,3,4,5:   step(1,0,0,0,0,s);
                    6,7,8,9,10:    step(0,1,0,0,0,s);
                    11,12,13,14:   step(0,0,1,0,0,s);
                    15:            step(0,0,0,1,0,s);
                    16:            step(0,0,0,0,1,s);
                    17:            step(1,1,0,0,0,s);
                    18:            step(1,0,1,0,0,s);
                    default:       step(0,1,0,1,0,s);
                endcase
            end
            if (k % 16 == 15) chk("rand_sold_out", int'(sold_out), exp_sold_out());
        end
        step(0,0,0,1,0,4'b0);
        chk("final_credit", int'(credit), m_credit);
        chk("final_pending", pending(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
